mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port memory arbiter and fetch sequencer between the instruction-fetch stage and the data-memory stage. Shares one synchronous RAM (1-cycle read latency) between the fetch requester (PC-addressed) and the load/store requester, and drives the PC hold signal while fetch is denied. Data accesses win by default, with an optional anti-starvation rule for fetch.

## Interface
- ADDR_W, 32, address width for both requesters and the RAM
- DATA_W, 32, data width
- MAX_STREAK, 4, max consecutive data grants while fetch waits (≥1; used only with the fairness feature)
- clock  in  1  single clock, rising edge
- reset_n  in  1  synchronous active-low reset; sampled on the rising edge of clock
- if_req  in  1  fetch request; held until if_gnt
- if_addr  in  ADDR_W  fetch address (PC); stable while if_req is high
- if_gnt  out  1  fetch accepted this cycle
- if_valid  out  1  if_rdata valid (cycle after if_gnt)
- if_rdata  out  DATA_W  instruction word
- d_req  in  1  data request; held until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data accepted this cycle
- d_valid  out  1  load data valid or store completion ack (cycle after d_gnt)
- d_rdata  out  DATA_W  load data; 0 on store acks
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_we  out  1  RAM write enable
- ram_rdata  in  DATA_W  RAM read data, valid one cycle after address
- stall_pc  out  1  hold PC: if_req high and if_gnt low

## Operation
- Grant decision is combinational each cycle. At most one grant per cycle. Grants may issue back-to-back every cycle.
- Priority: d_req over if_req. When only one request is present, that requester is granted.
- The granted requester's addr, wdata and we are muxed to the RAM in the grant cycle. With no grant: ram_we = 0, ram_addr holds its last value, ram_wdata = 0.
- The FSM records the access issued in the previous cycle and steers the response. States: IDLE, RD_IF, RD_D, WR_D.
  - Next state is chosen from this cycle's grant: fetch → RD_IF; data load → RD_D; store → WR_D; no grant → IDLE.
  - In RD_IF: if_valid = 1, if_rdata = ram_rdata.
  - In RD_D: d_valid = 1, d_rdata = ram_rdata.
  - In WR_D: d_valid = 1, d_rdata = 0.
  - In IDLE: no valid.
- Outside their valid cycle, if_rdata and d_rdata hold the last value driven.
- Store followed immediately by a load to the same address: the load returns the new data (the RAM writes before it reads on the next edge).

## Timing
- Latency: request seen in cycle N with grant → valid and data in cycle N+1. A fetch blocked for k cycles sees if_valid at N+k+1.
- Reset values: state = IDLE, if_valid = d_valid = 0, if_rdata = d_rdata = 0, ram_addr = 0, ram_we = 0, streak = 0.
- The gnt outputs and stall_pc depend combinationally on the inputs and are forced to 0 while reset_n = 0.
- Reset mid-operation: an in-flight read is dropped, and no valid is asserted in the cycle after reset deasserts.
- Simultaneous if_req and d_req: d_gnt = 1 and stall_pc = 1, unless the fairness rule applies.
- Dropping a request before its grant is illegal. The bench flags it; the design behaviour is undefined.

## Configuration
- MEM_ARB_FAIR_EN defined:
  - A streak counter increments on each data grant issued while if_req is high.
  - When streak == MAX_STREAK and both requests are present, fetch is granted.
  - Streak clears on any fetch grant, and also when if_req is low.
- MEM_ARB_FAIR_EN undefined: strict data priority; the counter logic is absent and fetch may starve indefinitely.

## Structure
- Package mem_arb_pkg holds:
  - state enum (IDLE, RD_IF, RD_D, WR_D)
  - owner encoding (OWN_NONE, OWN_IF, OWN_D)
  - streak width constant $clog2(MAX_STREAK+1)
- One sub-module, arb_streak_ctr (counter plus limit compare), instantiated only under MEM_ARB_FAIR_EN.

## Test plan
- Fetch only: if_req = 1, if_addr = 0x0, 0x4, 0x8 back-to-back with RAM preloaded → if_gnt every cycle; if_valid one cycle later with matching words; stall_pc = 0 throughout.
- Contention: if_req = 1 (addr 0x10) and a d_req load from 0x100 in the same cycle → d_gnt = 1, stall_pc = 1; next cycle if_gnt = 1 and d_valid returns mem[0x100]; if_valid follows one cycle later.
- Store then load: store 0xDEADBEEF to 0x40, load from 0x40 in the next cycle → store ack d_valid with d_rdata = 0, then d_rdata = 0xDEADBEEF.
- Starvation, MAX_STREAK = 4, with MEM_ARB_FAIR_EN: d_req held for 10 cycles with if_req = 1 → if_gnt in cycle 5 and cycle 10. Without the macro: no if_gnt over the 10 cycles.
- Reset mid-read: assert reset_n = 0 in the cycle after a data grant → no d_valid; all outputs at reset values; a normal fetch succeeds after release.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the mem_arbiter slice: response state, grant owner and streak sizing.
// Optional fetch fairness is enabled with the MEM_ARB_FAIR_EN macro (see mem_arbiter).
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_IF = 2'd1,
    RD_D  = 2'd2,
    WR_D  = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  localparam int MAX_STREAK_DEF = 4;

  // Enough bits to hold 0..max_streak inclusive.
  function automatic int streak_width(input int max_streak);
    return (max_streak < 1) ? 1 : $clog2(max_streak + 1);
  endfunction

  localparam int STREAK_W = streak_width(MAX_STREAK_DEF);

endpackage

// File: rtl/arb_streak_ctr.sv
// Counts consecutive data grants issued while fetch is waiting and flags the limit.
// Only instantiated by mem_arbiter when MEM_ARB_FAIR_EN is defined.
module arb_streak_ctr
  import mem_arb_pkg::*;
#(
  parameter int MAX_STREAK = MAX_STREAK_DEF,
  parameter int STREAK_W   = streak_width(MAX_STREAK)
) (
  input  logic clock,
  input  logic reset_n,
  input  logic if_req,
  input  logic if_gnt,
  input  logic d_gnt,
  output logic at_limit
);

  localparam logic [STREAK_W-1:0] LIMIT = STREAK_W'(MAX_STREAK);

  logic [STREAK_W-1:0] streak_q;
  logic [STREAK_W-1:0] streak_d;

  always_comb begin
    streak_d = streak_q;
    if (!if_req || if_gnt) begin
      streak_d = '0;
    end else if (d_gnt && (streak_q != LIMIT)) begin
      streak_d = streak_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

  assign at_limit = (streak_q == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between fetch and load/store with 1-cycle response steering.
// Define MEM_ARB_FAIR_EN to let fetch win after MAX_STREAK back-to-back data grants.
//
// state | meaning
// IDLE  | no access issued last cycle, no response this cycle
// RD_IF | fetch read issued last cycle, return ram_rdata on if_rdata
// RD_D  | data load issued last cycle, return ram_rdata on d_rdata
// WR_D  | store issued last cycle, ack on d_valid with d_rdata = 0
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_STREAK = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              stall_pc
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_RD_IF = RD_IF;
  localparam logic [1:0] ST_RD_D  = RD_D;
  localparam logic [1:0] ST_WR_D  = WR_D;

  if (MAX_STREAK < 1) begin : g_bad_max_streak
    $error("mem_arbiter: MAX_STREAK must be at least 1");
  end

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  owner_e            owner;
  logic              fetch_forced;

`ifdef MEM_ARB_FAIR_EN
  logic streak_at_limit;

  arb_streak_ctr #(
    .MAX_STREAK(MAX_STREAK),
    .STREAK_W  (streak_width(MAX_STREAK))
  ) u_streak_ctr (
    .clock   (clock),
    .reset_n (reset_n),
    .if_req  (if_req),
    .if_gnt  (if_gnt),
    .d_gnt   (d_gnt),
    .at_limit(streak_at_limit)
  );

  assign fetch_forced = if_req && d_req && streak_at_limit;
`else
  assign fetch_forced = 1'b0;
`endif

  // Data wins unless the fairness limit hands this cycle to fetch.
  always_comb begin
    owner = OWN_NONE;
    if (reset_n) begin
      if (d_req && !fetch_forced) begin
        owner = OWN_D;
      end else if (if_req) begin
        owner = OWN_IF;
      end
    end
  end

  assign if_gnt   = (owner == OWN_IF);
  assign d_gnt    = (owner == OWN_D);
  assign stall_pc = reset_n && if_req && !if_gnt;

  always_comb begin
    ram_addr_d = ram_addr_q;
    ram_wdata  = '0;
    ram_we     = 1'b0;
    state_d    = ST_IDLE;
    case (owner)
      OWN_IF: begin
        ram_addr_d = if_addr;
        state_d    = ST_RD_IF;
      end
      OWN_D: begin
        ram_addr_d = d_addr;
        if (d_we) begin
          ram_wdata = d_wdata;
          ram_we    = 1'b1;
          state_d   = ST_WR_D;
        end else begin
          state_d   = ST_RD_D;
        end
      end
      default: ;
    endcase
  end

  assign ram_addr = ram_addr_d;

  // Valids are masked during reset so an in-flight read never surfaces.
  assign if_valid = reset_n && (state_q == ST_RD_IF);
  assign d_valid  = reset_n && ((state_q == ST_RD_D) || (state_q == ST_WR_D));

  always_comb begin
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if (if_valid) begin
      if_rdata_d = ram_rdata;
    end
    if (d_valid) begin
      d_rdata_d = (state_q == ST_WR_D) ? '0 : ram_rdata;
    end
  end

  assign if_rdata = if_rdata_d;
  assign d_rdata  = d_rdata_d;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      ram_addr_q <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      ram_addr_q <= ram_addr_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural 1-cycle RAM.
// Expected starvation pattern follows MEM_ARB_FAIR_EN when it is defined for the build.
module tb_mem_arbiter;

`ifdef MEM_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_valid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_valid;
  logic [31:0] d_rdata;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_we;
  logic [31:0] ram_rdata;
  logic        stall_pc;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mem_arbiter #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .MAX_STREAK(4)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_gnt   (if_gnt),
    .if_valid (if_valid),
    .if_rdata (if_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .d_valid  (d_valid),
    .d_rdata  (d_rdata),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
    .ram_we   (ram_we),
    .ram_rdata(ram_rdata),
    .stall_pc (stall_pc)
  );

  // RAM latches its request mid-cycle so DUT register updates at the edge cannot race it.
  logic [31:0] mem [0:255];
  logic [31:0] ram_addr_s;
  logic [31:0] ram_wdata_s;
  logic        ram_we_s = 1'b0;

  always @(negedge clock) begin
    ram_addr_s  <= ram_addr;
    ram_wdata_s <= ram_wdata;
    ram_we_s    <= ram_we;
  end

  always @(posedge clock) begin
    if (ram_we_s) mem[ram_addr_s[9:2]] <= ram_wdata_s;
    ram_rdata <= mem[ram_addr_s[9:2]];
  end

  // Requests must be held until granted.
  logic pend_if = 1'b0;
  logic pend_d  = 1'b0;

  always @(negedge clock) begin
    if (reset_n && pend_if && !if_req) begin
      errors++;
      $error("FAIL if_req_dropped observed=0 expected=1");
    end
    if (reset_n && pend_d && !d_req) begin
      errors++;
      $error("FAIL d_req_dropped observed=0 expected=1");
    end
    pend_if = reset_n && if_req && !if_gnt;
    pend_d  = reset_n && d_req && !d_gnt;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic smp();
    @(negedge clock);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + i;

    reset_n = 1'b0;
    if_req  = 1'b0;
    if_addr = '0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    tick();
    tick();

    // Requests during reset must not be granted.
    if_req = 1'b1;
    d_req  = 1'b1;
    smp();
    chk("rst_if_gnt", if_gnt, 0);
    chk("rst_d_gnt", d_gnt, 0);
    chk("rst_stall", stall_pc, 0);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_d_valid", d_valid, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_we", ram_we, 0);
    tick();
    reset_n = 1'b1;
    if_req  = 1'b0;
    d_req   = 1'b0;

    // Fetch only, back-to-back.
    if_req = 1'b1; if_addr = 32'h0;
    smp();
    chk("f0_if_gnt", if_gnt, 1);
    chk("f0_stall", stall_pc, 0);
    chk("f0_d_gnt", d_gnt, 0);
    chk("f0_ram_addr", ram_addr, 32'h0);
    chk("f0_if_valid", if_valid, 0);
    tick();
    if_addr = 32'h4;
    smp();
    chk("f1_if_gnt", if_gnt, 1);
    chk("f1_ram_addr", ram_addr, 32'h4);
    chk("f1_if_valid", if_valid, 1);
    chk("f1_if_rdata", if_rdata, 32'hA000_0000);
    chk("f1_stall", stall_pc, 0);
    tick();
    if_addr = 32'h8;
    smp();
    chk("f2_if_gnt", if_gnt, 1);
    chk("f2_if_valid", if_valid, 1);
    chk("f2_if_rdata", if_rdata, 32'hA000_0001);
    tick();
    if_req = 1'b0;
    smp();
    chk("f3_if_valid", if_valid, 1);
    chk("f3_if_rdata", if_rdata, 32'hA000_0002);
    chk("f3_if_gnt", if_gnt, 0);
    chk("f3_ram_addr_hold", ram_addr, 32'h8);
    chk("f3_ram_wdata", ram_wdata, 0);
    tick();
    smp();
    chk("f4_if_valid", if_valid, 0);
    chk("f4_if_rdata_hold", if_rdata, 32'hA000_0002);
    chk("f4_ram_addr_hold", ram_addr, 32'h8);
    tick();

    // Contention: data load wins, fetch follows.
    if_req = 1'b1; if_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    smp();
    chk("c0_d_gnt", d_gnt, 1);
    chk("c0_if_gnt", if_gnt, 0);
    chk("c0_stall", stall_pc, 1);
    chk("c0_ram_addr", ram_addr, 32'h100);
    chk("c0_ram_we", ram_we, 0);
    tick();
    d_req = 1'b0;
    smp();
    chk("c1_if_gnt", if_gnt, 1);
    chk("c1_stall", stall_pc, 0);
    chk("c1_d_valid", d_valid, 1);
    chk("c1_d_rdata", d_rdata, 32'hA000_0040);
    chk("c1_ram_addr", ram_addr, 32'h10);
    tick();
    if_req = 1'b0;
    smp();
    chk("c2_if_valid", if_valid, 1);
    chk("c2_if_rdata", if_rdata, 32'hA000_0004);
    chk("c2_d_valid", d_valid, 0);
    chk("c2_d_rdata_hold", d_rdata, 32'hA000_0040);
    tick();

    // Store then load to the same address.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF;
    smp();
    chk("s0_d_gnt", d_gnt, 1);
    chk("s0_ram_we", ram_we, 1);
    chk("s0_ram_wdata", ram_wdata, 32'hDEAD_BEEF);
    chk("s0_ram_addr", ram_addr, 32'h40);
    tick();
    d_we = 1'b0; d_wdata = 32'h1234_5678;
    smp();
    chk("s1_d_valid", d_valid, 1);
    chk("s1_d_rdata_ack", d_rdata, 0);
    chk("s1_ram_we", ram_we, 0);
    chk("s1_ram_wdata", ram_wdata, 0);
    chk("s1_ram_addr", ram_addr, 32'h40);
    tick();
    d_req = 1'b0;
    smp();
    chk("s2_d_valid", d_valid, 1);
    chk("s2_d_rdata", d_rdata, 32'hDEAD_BEEF);
    tick();

    // Data held for 10 cycles while fetch waits.
    for (int k = 1; k <= 10; k++) begin
      if_req = 1'b1; if_addr = 32'h20;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h104;
      smp();
      chk($sformatf("st%0d_if_gnt", k), if_gnt, FAIR && (k == 5 || k == 10));
      chk($sformatf("st%0d_d_gnt", k), d_gnt, !(FAIR && (k == 5 || k == 10)));
      chk($sformatf("st%0d_stall", k), stall_pc, !(FAIR && (k == 5 || k == 10)));
      if (k >= 2) chk($sformatf("st%0d_if_valid", k), if_valid, FAIR && (k == 6));
      tick();
    end
    d_req = 1'b0;
    smp();
    chk("st11_if_gnt", if_gnt, 1);
    chk("st11_d_valid", d_valid, !FAIR);
    tick();
    if_req = 1'b0;
    smp();
    chk("st12_if_valid", if_valid, 1);
    chk("st12_if_rdata", if_rdata, 32'hA000_0008);
    tick();

    // Reset in the cycle after a data grant.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    smp();
    chk("r0_d_gnt", d_gnt, 1);
    tick();
    reset_n = 1'b0;
    d_req   = 1'b0;
    smp();
    chk("r1_d_valid", d_valid, 0);
    chk("r1_d_gnt", d_gnt, 0);
    tick();
    reset_n = 1'b1;
    smp();
    chk("r2_d_valid", d_valid, 0);
    chk("r2_if_valid", if_valid, 0);
    chk("r2_d_rdata", d_rdata, 0);
    chk("r2_if_rdata", if_rdata, 0);
    chk("r2_ram_addr", ram_addr, 0);
    chk("r2_ram_we", ram_we, 0);
    tick();
    if_req = 1'b1; if_addr = 32'hC;
    smp();
    chk("r3_if_gnt", if_gnt, 1);
    chk("r3_ram_addr", ram_addr, 32'hC);
    tick();
    if_req = 1'b0;
    smp();
    chk("r4_if_valid", if_valid, 1);
    chk("r4_if_rdata", if_rdata, 32'hA000_0003);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
